stripe_buf_ctrl: RTL and testbench

//  Ping-pong controller for the two 8-line stripe buffers between the block decoder and the HDMI output.

---
 rtl/stripe_buf_ctrl_pkg.sv | 17 +
 rtl/stripe_buf_ctrl_blk_addr_gen.sv | 88 ++++++++
 rtl/stripe_buf_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_stripe_buf_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/stripe_buf_ctrl_pkg.sv
// Shared types and helpers for the stripe ping-pong controller.
package stripe_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } buf_state_t;

  localparam int BLOCK_SIZE = 8;

  function automatic int stripe_depth(input int x_res, input int n, input int bs);
    return (x_res * bs) / n;
  endfunction

endpackage

// File: rtl/stripe_buf_ctrl_blk_addr_gen.sv
// Block-order to raster address generator: walks elem/line/block counters and
// keeps the raster address with adders only.
module blk_addr_gen #(
  parameter int N          = 2,
  parameter int X_RES      = 2160,
  parameter int BLOCK_SIZE = 8,
  parameter int AW         = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam int EPB = BLOCK_SIZE / N;
  localparam int LB  = X_RES / N;
  localparam int EW  = (EPB > 1) ? $clog2(EPB) : 1;
  localparam int LW  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  logic [EW-1:0] elem_r, elem_b_s, elem_n_s;
  logic [LW-1:0] line_r, line_b_s, line_n_s;
  logic [AW-1:0] blk_base_r, blk_b_s, blk_n_s;
  logic [AW-1:0] row_base_r, row_b_s, row_n_s;

  // Next counter values; clear together with step lands on beat 1.
  always_comb begin
    elem_b_s = elem_r;
    line_b_s = line_r;
    blk_b_s  = blk_base_r;
    row_b_s  = row_base_r;
    if (clear) begin
      elem_b_s = '0;
      line_b_s = '0;
      blk_b_s  = '0;
      row_b_s  = '0;
    end else begin
      elem_b_s = elem_r;
    end
    elem_n_s = elem_b_s;
    line_n_s = line_b_s;
    blk_n_s  = blk_b_s;
    row_n_s  = row_b_s;
    if (step) begin
      if (elem_b_s != EW'(EPB - 1)) begin
        elem_n_s = elem_b_s + EW'(1);
      end else begin
        elem_n_s = '0;
        if (line_b_s != LW'(BLOCK_SIZE - 1)) begin
          line_n_s = line_b_s + LW'(1);
          row_n_s  = row_b_s + AW'(LB);
        end else begin
          line_n_s = '0;
          if (blk_b_s == AW'(LB - EPB)) begin
            blk_n_s = '0;
            row_n_s = '0;
          end else begin
            blk_n_s = blk_b_s + AW'(EPB);
            row_n_s = blk_b_s + AW'(EPB);
          end
        end
      end
    end else begin
      elem_n_s = elem_b_s;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      elem_r     <= '0;
      line_r     <= '0;
      blk_base_r <= '0;
      row_base_r <= '0;
    end else begin
      elem_r     <= elem_n_s;
      line_r     <= line_n_s;
      blk_base_r <= blk_n_s;
      row_base_r <= row_n_s;
    end
  end

  assign addr = row_base_r + AW'(elem_r);
  assign last = (elem_r == EW'(EPB - 1)) && (line_r == LW'(BLOCK_SIZE - 1)) &&
                (blk_base_r == AW'(LB - EPB));

endmodule

// File: rtl/stripe_buf_ctrl.sv
// Ping-pong ownership and address controller for two 8-line stripe buffers
// sitting between the block decoder and the raster output.
module stripe_buf_ctrl #(
  parameter int  N          = 2,
  parameter int  X_RES      = 2160,
  parameter int  BLOCK_SIZE = 8,
  localparam int DEPTH      = stripe_pkg::stripe_depth(X_RES, N, BLOCK_SIZE),
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic          wr_sof,
  output logic          wr_ready,
  output logic [1:0]    wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          rd_avail,
  input  logic          rd_start,
  input  logic          rd_en,
  output logic          rd_sel,
  output logic [AW-1:0] rd_addr,
  output logic          rd_sof,
  output logic          rd_done,
  output logic          err_ovf,
  output logic          err_udf,
  output logic          err_resync
);

  import stripe_pkg::*;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  buf_state_t    buf_state_r [2];
  buf_state_t    buf_state_n [2];
  logic [1:0]    buf_sof_r, buf_sof_n;
  logic          wr_buf_r, wr_buf_n;
  logic          synced_r, synced_n;
  logic          cur_sof_r, cur_sof_n;
  logic          rd_next_r, rd_next_n;
  logic          rd_sel_r, rd_sel_n;
  logic [AW-1:0] rd_addr_r, rd_addr_n;
  logic          rd_sof_r, rd_sof_n;

  logic          wr_ready_r, wr_ready_n;
  logic [1:0]    wr_en_r, wr_en_n;
  logic [AW-1:0] wr_addr_r, wr_addr_n;
  logic          rd_avail_r, rd_avail_n;
  logic          rd_done_r, rd_done_n;
  logic          err_ovf_r, err_ovf_n;
  logic          err_udf_r, err_udf_n;
  logic          err_resync_r, err_resync_n;

  logic [AW-1:0] gen_addr_s;
  logic          gen_last_s;
  logic          accept_s, mid_s, write_s, restart_s, beat0_s, complete_s;
  logic          reading_s, rd_step_s, rd_last_s, start_ok_s;

  blk_addr_gen #(
    .N          (N),
    .X_RES      (X_RES),
    .BLOCK_SIZE (BLOCK_SIZE),
    .AW         (AW)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (restart_s),
    .step  (write_s),
    .addr  (gen_addr_s),
    .last  (gen_last_s)
  );

  // Beats before the first sof are accepted but never written.
  assign accept_s   = wr_valid & wr_ready_r;
  assign mid_s      = (gen_addr_s != '0);
  assign write_s    = accept_s & (synced_r | wr_sof);
  assign restart_s  = write_s & synced_r & wr_sof & mid_s;
  assign beat0_s    = write_s & (restart_s | ~mid_s);
  assign complete_s = write_s & ~restart_s & gen_last_s;
  assign reading_s  = (buf_state_r[rd_sel_r] == READING);
  assign rd_step_s  = rd_en & reading_s;
  assign rd_last_s  = rd_step_s & (rd_addr_r == LAST_ADDR);
  assign start_ok_s = rd_start & rd_avail_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_state_r[0] <= EMPTY;
      buf_state_r[1] <= EMPTY;
      buf_sof_r      <= 2'b00;
      wr_buf_r       <= 1'b0;
      synced_r       <= 1'b0;
      cur_sof_r      <= 1'b0;
      rd_next_r      <= 1'b0;
      rd_sel_r       <= 1'b0;
      rd_addr_r      <= '0;
      rd_sof_r       <= 1'b0;
    end else begin
      buf_state_r[0] <= buf_state_n[0];
      buf_state_r[1] <= buf_state_n[1];
      buf_sof_r      <= buf_sof_n;
      wr_buf_r       <= wr_buf_n;
      synced_r       <= synced_n;
      cur_sof_r      <= cur_sof_n;
      rd_next_r      <= rd_next_n;
      rd_sel_r       <= rd_sel_n;
      rd_addr_r      <= rd_addr_n;
      rd_sof_r       <= rd_sof_n;
    end
  end

  // Next state; fill and drain always target different buffers.
  always_comb begin
    buf_state_n = buf_state_r;
    buf_sof_n   = buf_sof_r;
    wr_buf_n    = wr_buf_r;
    synced_n    = synced_r;
    cur_sof_n   = cur_sof_r;
    rd_next_n   = rd_next_r;
    rd_sel_n    = rd_sel_r;
    rd_addr_n   = rd_addr_r;
    rd_sof_n    = rd_sof_r;

    if (write_s) begin
      synced_n = 1'b1;
      if (beat0_s) begin
        cur_sof_n = wr_sof;
      end else begin
        cur_sof_n = cur_sof_r;
      end
      if (complete_s) begin
        buf_state_n[wr_buf_r] = FULL;
        buf_sof_n[wr_buf_r]   = cur_sof_r;
        wr_buf_n              = ~wr_buf_r;
      end else begin
        buf_state_n[wr_buf_r] = FILLING;
      end
    end else begin
      synced_n = synced_r;
    end

    if (rd_last_s) begin
      buf_state_n[rd_sel_r] = EMPTY;
      rd_addr_n             = '0;
      rd_sof_n              = 1'b0;
    end else if (rd_step_s) begin
      rd_addr_n = rd_addr_r + AW'(1);
    end else if (start_ok_s) begin
      buf_state_n[rd_next_r] = READING;
      rd_sel_n               = rd_next_r;
      rd_next_n              = ~rd_next_r;
      rd_addr_n              = '0;
      rd_sof_n               = buf_sof_r[rd_next_r];
    end else begin
      rd_addr_n = rd_addr_r;
    end
  end

  // Output decode from the next state so registered flags line up with it.
  always_comb begin
    wr_ready_n   = (buf_state_n[wr_buf_n] == EMPTY) || (buf_state_n[wr_buf_n] == FILLING);
    rd_avail_n   = (buf_state_n[rd_next_n] == FULL) &&
                   (buf_state_n[0] != READING) && (buf_state_n[1] != READING);
    wr_en_n      = 2'b00;
    wr_addr_n    = wr_addr_r;
    if (write_s) begin
      wr_en_n   = wr_buf_r ? 2'b10 : 2'b01;
      wr_addr_n = restart_s ? '0 : gen_addr_s;
    end else begin
      wr_en_n = 2'b00;
    end
    rd_done_n    = rd_last_s;
    err_ovf_n    = wr_valid & ~wr_ready_r & synced_r;
    err_udf_n    = (rd_start & ~rd_avail_r) | (rd_en & ~reading_s);
    err_resync_n = restart_s;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ready_r   <= 1'b1;
      wr_en_r      <= 2'b00;
      wr_addr_r    <= '0;
      rd_avail_r   <= 1'b0;
      rd_done_r    <= 1'b0;
      err_ovf_r    <= 1'b0;
      err_udf_r    <= 1'b0;
      err_resync_r <= 1'b0;
    end else begin
      wr_ready_r   <= wr_ready_n;
      wr_en_r      <= wr_en_n;
      wr_addr_r    <= wr_addr_n;
      rd_avail_r   <= rd_avail_n;
      rd_done_r    <= rd_done_n;
      err_ovf_r    <= err_ovf_n;
      err_udf_r    <= err_udf_n;
      err_resync_r <= err_resync_n;
    end
  end

  assign wr_ready   = wr_ready_r;
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign rd_avail   = rd_avail_r;
  assign rd_sel     = rd_sel_r;
  assign rd_addr    = rd_addr_r;
  assign rd_sof     = rd_sof_r;
  assign rd_done    = rd_done_r;
  assign err_ovf    = err_ovf_r;
  assign err_udf    = err_udf_r;
  assign err_resync = err_resync_r;

endmodule

// File: tb/tb_stripe_buf_ctrl.sv
// Bench for stripe_buf_ctrl: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based stripe model.
module tb_stripe_buf_ctrl;

  localparam int N     = 2;
  localparam int X_RES = 16;
  localparam int BS    = 8;
  localparam int DEPTH = X_RES * BS / N;
  localparam int AW    = $clog2(DEPTH);
  localparam int EPB   = BS / N;
  localparam int LB    = X_RES / N;

  logic          clk = 1'b0;
  logic          rst, wr_valid, wr_sof, rd_start, rd_en;
  logic          wr_ready, rd_avail, rd_sel, rd_sof, rd_done;
  logic          err_ovf, err_udf, err_resync;
  logic [1:0]    wr_en;
  logic [AW-1:0] wr_addr, rd_addr;

  always #5 clk = ~clk;

  stripe_buf_ctrl #(.N(N), .X_RES(X_RES), .BLOCK_SIZE(BS)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_ready(wr_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_avail(rd_avail), .rd_start(rd_start),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_sof(rd_sof),
    .rd_done(rd_done), .err_ovf(err_ovf), .err_udf(err_udf), .err_resync(err_resync)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: 0 empty, 1 filling, 2 full, 3 reading.
  int bst [2];
  bit bsof [2];
  int full_q [$];
  int wbuf, pos, rbuf, raddr;
  bit synced, cur_sof, reading;
  int e_wr_ready, e_wr_en, e_wr_addr, e_rd_avail, e_rd_sel, e_rd_addr;
  int e_rd_sof, e_rd_done, e_ovf, e_udf, e_resync;

  function automatic int addr_of(input int k);
    int blk, r;
    blk = k / (EPB * BS);
    r   = k % (EPB * BS);
    return blk * EPB + (r / EPB) * LB + (r % EPB);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ready_pre, avail_pre, reading_pre, synced_pre;
    if (rst) begin
      bst[0] = 0; bst[1] = 0; bsof[0] = 0; bsof[1] = 0;
      full_q.delete();
      wbuf = 0; pos = 0; rbuf = 0; raddr = 0;
      synced = 0; cur_sof = 0; reading = 0;
      e_wr_ready = 1; e_wr_en = 0; e_wr_addr = 0; e_rd_avail = 0; e_rd_sel = 0;
      e_rd_addr = 0; e_rd_sof = 0; e_rd_done = 0; e_ovf = 0; e_udf = 0; e_resync = 0;
    end else begin
      ready_pre = (e_wr_ready != 0); avail_pre = (e_rd_avail != 0);
      reading_pre = reading; synced_pre = synced;
      e_wr_en = 0; e_rd_done = 0; e_ovf = 0; e_udf = 0; e_resync = 0;
      if (rd_en) begin
        if (reading_pre) begin
          raddr++;
          if (raddr == DEPTH) begin
            bst[rbuf] = 0; reading = 0; raddr = 0; e_rd_done = 1; e_rd_sof = 0;
          end
        end else e_udf = 1;
      end
      if (rd_start) begin
        if (avail_pre) begin
          rbuf = full_q.pop_front();
          bst[rbuf] = 3; reading = 1; raddr = 0;
          e_rd_sel = rbuf; e_rd_sof = bsof[rbuf];
        end else e_udf = 1;
      end
      if (wr_valid) begin
        if (!ready_pre) begin
          if (synced_pre) e_ovf = 1;
        end else if (synced || wr_sof) begin
          if (synced && wr_sof && pos != 0) begin
            e_resync = 1; pos = 0;
          end
          synced = 1;
          if (pos == 0) begin
            cur_sof = wr_sof; bst[wbuf] = 1;
          end
          e_wr_en = 1 << wbuf;
          e_wr_addr = addr_of(pos);
          pos++;
          if (pos == DEPTH) begin
            bst[wbuf] = 2; bsof[wbuf] = cur_sof; full_q.push_back(wbuf);
            wbuf ^= 1; pos = 0;
          end
        end
      end
      e_wr_ready = (bst[wbuf] <= 1) ? 1 : 0;
      e_rd_avail = (full_q.size() != 0 && !reading) ? 1 : 0;
      e_rd_addr  = raddr;
    end
  endtask

  task automatic cyc(input bit v, input bit s, input bit rs, input bit re);
    wr_valid = v; wr_sof = s; rd_start = rs; rd_en = re;
    @(posedge clk);
    #1;
    model_step();
  endtask

  // Compare every DUT output against the model away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_ready", int'(wr_ready), e_wr_ready);
      check("wr_en", int'(wr_en), e_wr_en);
      if (e_wr_en != 0) check("wr_addr", int'(wr_addr), e_wr_addr);
      check("rd_avail", int'(rd_avail), e_rd_avail);
      check("rd_sel", int'(rd_sel), e_rd_sel);
      check("rd_addr", int'(rd_addr), e_rd_addr);
      check("rd_sof", int'(rd_sof), e_rd_sof);
      check("rd_done", int'(rd_done), e_rd_done);
      check("err_ovf", int'(err_ovf), e_ovf);
      check("err_udf", int'(err_udf), e_udf);
      check("err_resync", int'(err_resync), e_resync);
    end
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_sof = 1'b0; rd_start = 1'b0; rd_en = 1'b0;
    cyc(0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    check("rst_wr_ready", int'(wr_ready), 1);
    check("rst_rd_avail", int'(rd_avail), 0);
    check("rst_wr_en", int'(wr_en), 0);

    repeat (3) cyc(1, 0, 0, 0);
    check("presync_wr_en", int'(wr_en), 0);
    check("presync_ready", int'(wr_ready), 1);

    for (int k = 0; k < DEPTH; k++) begin
      cyc(1, k == 0, 0, 0);
      if (k == 0)  check("t1_addr_b0", int'(wr_addr), 0);
      if (k == 4)  check("t1_addr_b4", int'(wr_addr), 8);
      if (k == 31) check("t1_addr_b31", int'(wr_addr), 59);
      if (k == 32) check("t1_addr_b32", int'(wr_addr), 4);
    end
    check("t1_wr_en", int'(wr_en), 1);
    check("t1_addr_last", int'(wr_addr), 63);
    check("t1_rd_avail", int'(rd_avail), 1);

    for (int k = 0; k < DEPTH; k++) cyc(1, 0, 0, 0);
    check("t3_ready_low", int'(wr_ready), 0);
    cyc(1, 0, 0, 0);
    check("t3_ovf", int'(err_ovf), 1);
    check("t3_no_wr", int'(wr_en), 0);

    cyc(0, 0, 1, 0);
    check("t4_rd_sel", int'(rd_sel), 0);
    check("t4_rd_sof", int'(rd_sof), 1);
    check("t4_avail_low", int'(rd_avail), 0);
    for (int k = 0; k < DEPTH; k++) begin
      cyc(0, 0, 0, 1);
      if (k == DEPTH - 2) check("t4_addr_63", int'(rd_addr), 63);
    end
    check("t4_done", int'(rd_done), 1);
    check("t4_addr_wrap", int'(rd_addr), 0);
    check("t4_ready", int'(wr_ready), 1);

    for (int k = 0; k < 20; k++) cyc(1, k == 0, 0, 0);
    cyc(1, 1, 0, 0);
    check("t5_resync", int'(err_resync), 1);
    check("t5_addr0", int'(wr_addr), 0);
    check("t5_wr_en", int'(wr_en), 1);
    cyc(0, 0, 0, 1);
    check("t5_udf", int'(err_udf), 1);

    cyc(0, 0, 1, 0);
    check("t6_rd_sel", int'(rd_sel), 1);
    check("t6_rd_sof", int'(rd_sof), 0);
    cyc(0, 0, 0, 1);
    for (int k = 0; k < DEPTH - 1; k++) cyc(1, 0, 0, 1);
    check("t6_done", int'(rd_done), 1);
    check("t6_last_wr", int'(wr_addr), 63);
    check("t6_avail", int'(rd_avail), 1);
    check("t6_ready", int'(wr_ready), 1);

    for (int i = 0; i < 6000; i++) begin
      rst = (i == 3000 || $urandom_range(0, 1999) == 0) ? 1'b1 : 1'b0;
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 8);
    end
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
